// File: rtl/md_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op codes,
// FSM states and the iteration count.
package md_pkg;

    localparam int MD_ITERATIONS = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_step.sv
// One combinational iteration: radix-2 Booth step over {hi, lo, q-1} for MULT,
// or one restoring shift/subtract step on unsigned magnitudes for DIV.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic             acc_q1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] nxt_hi_o,
    output logic [WIDTH-1:0] nxt_lo_o,
    output logic             nxt_q1_o
);

    // One extra bit so that subtracting the most negative multiplicand cannot overflow.
    logic [WIDTH:0] booth_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        booth_sum = {acc_hi_i[WIDTH-1], acc_hi_i};
        case ({acc_lo_i[0], acc_q1_i})
            2'b01:   booth_sum = {acc_hi_i[WIDTH-1], acc_hi_i} + {m_i[WIDTH-1], m_i};
            2'b10:   booth_sum = {acc_hi_i[WIDTH-1], acc_hi_i} - {m_i[WIDTH-1], m_i};
            default: booth_sum = {acc_hi_i[WIDTH-1], acc_hi_i};
        endcase

        rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, m_i};

        if (op_i == MD_OP_DIV) begin
            if (!trial[WIDTH]) begin
                nxt_hi_o = trial[WIDTH-1:0];
                nxt_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi_o = rem_sh[WIDTH-1:0];
                nxt_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
            end
            nxt_q1_o = 1'b0;
        end else begin
            nxt_hi_o = booth_sum[WIDTH:1];
            nxt_lo_o = {booth_sum[0], acc_lo_i[WIDTH-1:1]};
            nxt_q1_o = acc_lo_i[0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit with architectural HI/LO registers that
// update only when an operation completes.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_lo_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int                CNT_W     = $clog2(MD_ITERATIONS + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(MD_ITERATIONS - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dz_q;

    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, m_q;
    logic             acc_q1_q;
    logic             neg_quo_q, neg_rem_q;

    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_q1;
    logic             step_op;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             accept;

    assign accept  = (state_q == ST_IDLE) && start;
    assign step_op = (state_q == ST_DIV) ? MD_OP_DIV : MD_OP_MULT;
    assign abs_a   = a[WIDTH-1] ? -a : a;
    assign abs_b   = b[WIDTH-1] ? -b : b;

    md_step #(.WIDTH(WIDTH)) u_step (
        .op_i     (step_op),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .acc_q1_i (acc_q1_q),
        .m_i      (m_q),
        .nxt_hi_o (step_hi),
        .nxt_lo_o (step_lo),
        .nxt_q1_o (step_q1)
    );

    // Signs are reapplied to the last step's magnitudes as they are written to HI/LO.
    always_comb begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (state_q == ST_DIV) begin
            hi_d = neg_rem_q ? -step_hi : step_hi;
            lo_d = neg_quo_q ? -step_lo : step_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        if (op == MD_OP_DIV && b == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                        end else if (op == MD_OP_DIV) begin
                            state_q <= ST_DIV;
                        end else begin
                            state_q <= ST_MULT;
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dz_q    <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Working registers hold partial results only; they never need a reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_hi_q <= '0;
            acc_q1_q <= 1'b0;
            if (op == MD_OP_MULT) begin
                acc_lo_q <= b;
                m_q      <= a;
            end else begin
                acc_lo_q  <= abs_a;
                m_q       <= abs_b;
                neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_rem_q <= a[WIDTH-1];
            end
        end else if (state_q == ST_MULT || state_q == ST_DIV) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            acc_q1_q <= step_q1;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_out   = hi_lo_sel ? hi_q : lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: table vectors, corner-case sequences and random
// operations, with expected results queued at start and compared at done.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic        hi_lo_sel;
    logic [31:0] hi, lo, md_out;
    logic        busy, done, div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t        sb_q[$];
    vec_t        tbl[10];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hi_lo_sel (hi_lo_sel),
        .hi        (hi),
        .lo        (lo),
        .md_out    (md_out),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit integers, independent of the iterative hardware.
    function automatic vec_t model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] ph, input logic [31:0] pl);
        vec_t   r;
        longint sx, sy, p, q, m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.op = o; r.a = x; r.b = y; r.dz = 1'b0;
        if (!o) begin
            p    = sx * sy;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (y == 32'd0) begin
            r.hi = ph; r.lo = pl; r.dz = 1'b1;
        end else begin
            q    = sx / sy;
            m    = sx % sy;
            r.hi = m[31:0];
            r.lo = q[31:0];
        end
        return r;
    endfunction

    // ev_kind: 0 none, 1 extra start at cycle ev_cyc, 2 reset pulse at cycle ev_cyc
    task automatic do_op(input vec_t e, input int ev_cyc, input int ev_kind);
        vec_t got;
        int   cyc;
        int   want;
        logic seen;
        sb_q.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        start = 1'b1; op = e.op; a = e.a; b = e.b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", busy, 1);
        want = (e.op && e.b == 32'd0) ? 1 : 33;
        while (!done && cyc < 40) begin
            if (ev_kind == 1 && cyc == ev_cyc) begin
                start = 1'b1; op = ~e.op; a = e.a + 32'd5; b = e.b + 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (ev_kind == 2 && cyc == ev_cyc) begin
                reset_n = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_hi", hi, 0);
                check("abort_lo", lo, 0);
                sb_q.delete();
                last_hi = '0;
                last_lo = '0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                seen = 1'b0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (done) seen = 1'b1;
                end
                check("no_done_after_abort", seen, 0);
                return;
            end
        end
        check("done_latency", cyc, want);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            got = sb_q.pop_front();
            check("hi", hi, got.hi);
            check("lo", lo, got.lo);
            check("div_zero", div_zero, got.dz);
            hi_lo_sel = 1'b0; #1;
            check("md_out_lo", md_out, got.lo);
            hi_lo_sel = 1'b1; #1;
            check("md_out_hi", md_out, got.hi);
        end
        @(posedge clk); #1;
        check("done_drop", done, 0);
        check("busy_drop", busy, 0);
        check("dz_drop", div_zero, 0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[3] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_3412, 32'h0000_0100, 32'h0000_0012, 32'h0000_0034, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0012, 32'h0000_0034, 1'b1};
        tbl[7] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[8] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[9] = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};

        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; hi_lo_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) do_op(tbl[i], 0, 0);

        // Second start during MULT must be ignored.
        do_op(model(1'b0, 32'd3, 32'd5, last_hi, last_lo), 5, 1);
        // Reset pulse aborts a DIV; the following MULT must complete normally.
        do_op(model(1'b1, 32'd100, 32'd7, last_hi, last_lo), 10, 2);
        check("post_abort_hi", hi, 0);
        do_op(model(1'b0, 32'd6, 32'd7, last_hi, last_lo), 0, 0);

        for (int i = 0; i < 8; i++) begin
            logic        ro;
            logic [31:0] rx, ry;
            ro = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) ry = 32'($urandom_range(1, 9));
            do_op(model(ro, rx, ry, last_hi, last_lo), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
